// File: rtl/can_noc_pkt_injector_pkg.sv
// rtl/can_noc_pkt_injector_pkg.sv - flit layout constants and FSM states shared by the PE injector and the CAN node ingress.
package can_noc_pkt_injector_pkg;

  localparam int X           = 2;
  localparam int Y           = 2;
  localparam int X_SIZE      = 1;
  localparam int Y_SIZE      = 1;
  localparam int DATA_WIDTH  = 129;
  localparam int ADDR_W      = X_SIZE + Y_SIZE;
  localparam int TOTAL_WIDTH = ADDR_W + DATA_WIDTH;

  localparam logic [ADDR_W-1:0] CAN_NODE_ADDR = '0;

  localparam int ADDR_LSB    = 0;
  localparam int PAYLOAD_LSB = ADDR_W;
  localparam int BCAST_BIT   = TOTAL_WIDTH - 1;

  localparam int WORD_W        = 32;
  localparam int WORDS_PER_PKT = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

endpackage

// File: rtl/can_noc_pkt_injector.sv
// rtl/can_noc_pkt_injector.sv - packs four PE words plus broadcast flag into one CAN-bound NoC flit.
module can_noc_pkt_injector
  import can_noc_pkt_injector_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      i_word,
  input  logic                   i_word_valid,
  output logic                   o_word_ready,
  input  logic                   i_bcast,
  input  logic                   i_flush,
  output logic [TOTAL_WIDTH-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic [15:0]            o_pkt_count
);

  state_t                   state_q;
  logic [1:0]               idx_q;
  logic [WORD_W-1:0]        slots_q [WORDS_PER_PKT];
  logic                     bcast_q;
  logic [TOTAL_WIDTH-1:0]   data_q;
  logic                     valid_q;
  logic                     busy_q;
  logic [15:0]              cnt_q;

  logic                     accept;
  logic                     emit;
  logic [WORD_W-1:0]        slots_d [WORDS_PER_PKT];
  logic                     bcast_d;
  logic [TOTAL_WIDTH-1:0]   flit_d;

  assign o_word_ready = !rst && (state_q == COLLECT);
  assign accept       = i_word_valid && o_word_ready;

  // The flit is built from the slots as they will look after this edge's accept.
  always_comb begin
    for (int i = 0; i < WORDS_PER_PKT; i++) slots_d[i] = slots_q[i];
    bcast_d = bcast_q;
    if (accept) begin
      slots_d[idx_q] = i_word;
      if (idx_q == 2'd0) bcast_d = i_bcast;
    end
    emit = (state_q == COLLECT) &&
           ((accept && idx_q == 2'd3) || (i_flush && (idx_q != 2'd0 || accept)));
    flit_d = '0;
    flit_d[ADDR_LSB +: ADDR_W] = CAN_NODE_ADDR;
    for (int i = 0; i < WORDS_PER_PKT; i++)
      flit_d[PAYLOAD_LSB + WORD_W*i +: WORD_W] = slots_d[i];
    flit_d[BCAST_BIT] = bcast_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      for (int i = 0; i < WORDS_PER_PKT; i++) slots_q[i] <= '0;
      bcast_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (emit) begin
            // Slots are cleared as the flit leaves so the next partial packet pads with zeros.
            data_q  <= flit_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            for (int i = 0; i < WORDS_PER_PKT; i++) slots_q[i] <= '0;
            bcast_q <= 1'b0;
            state_q <= SEND;
          end else if (accept) begin
            for (int i = 0; i < WORDS_PER_PKT; i++) slots_q[i] <= slots_d[i];
            bcast_q <= bcast_d;
            idx_q   <= idx_q + 2'd1;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (valid_q && i_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= cnt_q + 16'd1;
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_pkt_count = cnt_q;

endmodule
